dequant_column_pipe: RTL

Parametrised JPEG inverse quantizer that multiplies each column of an 8x8 coefficient block by the matching column of a runtime-loadable quantization table. It sits between the entropy/zig-zag reorder stage and the column IDCT in the decode pipeline. It accepts one column per beat under valid/ready flow control. Per block, it selects one of several stored tables, so the luma and chroma channels share a single instance.

---
 rtl/dequant_pkg.sv | 54 +++++
 rtl/dequant_table_bank.sv | 57 +++++
 rtl/dequant_column_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dequant_pkg.sv
// rtl/dequant_pkg.sv - shared types, default quantization tables and product reduction
//
// Purpose: common definitions for the column dequantizer.
//   col_cnt_t        3-bit column-within-block counter type
//   LUMA_Q/CHROMA_Q  standard JPEG luma/chroma tables, row-major (row*8+col)
//   reduce_product   reduces a full-width product to the output width
// Build option: DEQUANT_SAT_EN selects clamping instead of two's-complement wrap.

package dequant_pkg;

   typedef logic [2:0] col_cnt_t;

   localparam int unsigned LUMA_Q [64] = '{
      16, 11, 10, 16, 24, 40, 51, 61,
      12, 12, 14, 19, 26, 58, 60, 55,
      14, 13, 16, 24, 40, 57, 69, 56,
      14, 17, 22, 29, 51, 87, 80, 62,
      18, 22, 37, 56, 68, 109, 103, 77,
      24, 35, 55, 64, 81, 104, 113, 92,
      49, 64, 78, 87, 103, 121, 120, 101,
      72, 92, 95, 98, 112, 100, 103, 99
   };

   localparam int unsigned CHROMA_Q [64] = '{
      17, 18, 24, 47, 99, 99, 99, 99,
      18, 21, 26, 66, 99, 99, 99, 99,
      24, 26, 56, 99, 99, 99, 99, 99,
      47, 66, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99
   };

   // Caller keeps the low out_w bits of the result.
   function automatic longint reduce_product(input longint prod, input int out_w);
`ifdef DEQUANT_SAT_EN
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (out_w - 1)) - 1;
      lo = -hi - 1;
      if (prod > hi)
         return hi;
      else if (prod < lo)
         return lo;
      else
         return prod;
`else
      // Plain wrap: only the low bits survive, the mask folds away.
      return prod & ((longint'(1) <<< out_w) - 1);
`endif
   endfunction

endpackage

// File: rtl/dequant_table_bank.sv
// rtl/dequant_table_bank.sv - NUM_TABLES x 64 quantizer register bank
//
// Purpose: holds the runtime-loadable quantization tables with reset defaults
// (table 0 luma, table 1 chroma, others all 1).
// Ports:
//   clk_in, rst_in   clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data   single write port, takes effect at the clock edge
//   rd_sel/rd_col    column read select
//   rd_data          8 entries of column rd_col, row r at [r*Q_W +: Q_W]

module dequant_table_bank
   import dequant_pkg::*;
#(
   parameter int Q_W        = 8,
   parameter int NUM_TABLES = 4,
   parameter int SEL_W      = $clog2(NUM_TABLES)
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_sel,
   input  logic [5:0]       wr_addr,
   input  logic [Q_W-1:0]   wr_data,
   input  logic [SEL_W-1:0] rd_sel,
   input  col_cnt_t         rd_col,
   output logic [8*Q_W-1:0] rd_data
);

   logic [Q_W-1:0] mem [NUM_TABLES][64];

   function automatic logic [Q_W-1:0] default_entry(input int t, input int a);
      if (t == 0)
         return Q_W'(LUMA_Q[a]);
      else if (t == 1)
         return Q_W'(CHROMA_Q[a]);
      else
         return Q_W'(1);
   endfunction

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int t = 0; t < NUM_TABLES; t++)
            for (int a = 0; a < 64; a++)
               mem[t][a] <= default_entry(t, a);
      end else if (wr_en) begin
         mem[wr_sel][wr_addr] <= wr_data;
      end
   end

   // Combinational read: a write in the same cycle is not yet visible.
   always_comb begin
      rd_data = '0;
      for (int r = 0; r < 8; r++)
         rd_data[r*Q_W +: Q_W] = mem[rd_sel][{3'(r), rd_col}];
   end

endmodule

// File: rtl/dequant_column_pipe.sv
// rtl/dequant_column_pipe.sv - two-stage JPEG column inverse quantizer (top)
//
// Purpose: multiplies each accepted 8-element column by the matching column of
// the table selected on the block's first beat.
// Build option: DEQUANT_SAT_EN clamps out-of-range products; default wraps.
// Ports:
//   clk_in, rst_in                 clock, asynchronous active-high reset
//   column_in/valid_in/ready_out   input column stream, element i at [i*COEF_W +: COEF_W]
//   tsel_in                        table select, sampled on column 0 of a block
//   column_out/valid_out/ready_in  output stream, element i at [i*OUT_W +: OUT_W]
//   last_out                       marks the 8th column of a block
//   tbl_we/tbl_sel/tbl_addr/tbl_data  table write port

module dequant_column_pipe
   import dequant_pkg::*;
#(
   parameter int COEF_W     = 12,
   parameter int OUT_W      = 16,
   parameter int Q_W        = 8,
   parameter int NUM_TABLES = 4
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic [8*COEF_W-1:0]           column_in,
   input  logic                          valid_in,
   output logic                          ready_out,
   input  logic [$clog2(NUM_TABLES)-1:0] tsel_in,
   output logic [8*OUT_W-1:0]            column_out,
   output logic                          valid_out,
   input  logic                          ready_in,
   output logic                          last_out,
   input  logic                          tbl_we,
   input  logic [$clog2(NUM_TABLES)-1:0] tbl_sel,
   input  logic [5:0]                    tbl_addr,
   input  logic [Q_W-1:0]                tbl_data
);

   localparam int SEL_W = $clog2(NUM_TABLES);
   localparam int PW    = COEF_W + Q_W + 1;

   col_cnt_t             col_cnt;
   logic [SEL_W-1:0]     act_sel;
   logic [SEL_W-1:0]     eff_sel;
   logic [8*Q_W-1:0]     rd_q;
   logic                 advance;
   logic                 accept;

   logic                 s1_valid;
   logic [8*COEF_W-1:0]  s1_coef;
   logic [8*Q_W-1:0]     s1_q;
   col_cnt_t             s1_col;

   logic signed [PW-1:0] prod [8];
   logic [8*OUT_W-1:0]   s2_next;

   // Whole pipe moves together; it only freezes when the output is held.
   assign advance   = !valid_out || ready_in;
   assign ready_out = advance;
   assign accept    = valid_in && advance;

   // Column 0 reads with the incoming select since act_sel is not latched yet.
   assign eff_sel = (col_cnt == '0) ? tsel_in : act_sel;

   dequant_table_bank #(
      .Q_W        (Q_W),
      .NUM_TABLES (NUM_TABLES),
      .SEL_W      (SEL_W)
   ) u_bank (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .wr_en   (tbl_we),
      .wr_sel  (tbl_sel),
      .wr_addr (tbl_addr),
      .wr_data (tbl_data),
      .rd_sel  (eff_sel),
      .rd_col  (col_cnt),
      .rd_data (rd_q)
   );

   // Signed coefficient times zero-extended entry.
   always_comb begin
      s2_next = '0;
      for (int i = 0; i < 8; i++) begin
         prod[i] = PW'($signed(s1_coef[i*COEF_W +: COEF_W]))
                 * PW'($signed({1'b0, s1_q[i*Q_W +: Q_W]}));
         s2_next[i*OUT_W +: OUT_W] = OUT_W'(reduce_product(longint'(prod[i]), OUT_W));
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         col_cnt    <= '0;
         act_sel    <= '0;
         s1_valid   <= 1'b0;
         s1_coef    <= '0;
         s1_q       <= '0;
         s1_col     <= '0;
         column_out <= '0;
         valid_out  <= 1'b0;
         last_out   <= 1'b0;
      end else begin
         if (accept) begin
            col_cnt <= col_cnt + 1'b1;
            if (col_cnt == '0)
               act_sel <= tsel_in;
         end
         if (advance) begin
            s1_valid <= accept;
            if (accept) begin
               s1_coef <= column_in;
               s1_q    <= rd_q;
               s1_col  <= col_cnt;
            end
            valid_out <= s1_valid;
            last_out  <= s1_valid && (s1_col == 3'd7);
            if (s1_valid)
               column_out <= s2_next;
         end
      end
   end

endmodule
